mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit for the pipelined MIPS core.
- Consumes the two source operands read from the register file (after forwarding muxes) and owns the HI/LO architectural registers.
- Multi-cycle: asserts busy while an operation is in flight so the hazard unit can stall MD-class instructions in D stage.
- HI/LO values feed the E-stage result mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, cycles from MULT/MULTU acceptance to HI/LO update (must be >=1)
- DIV_CYCLES, 10, cycles from DIV/DIVU acceptance to HI/LO update (must be >=1)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- md_en  input  1  E-stage instruction is an MDU write-type op (qualifies md_op)
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- busy  output  1  operation in flight; high exactly while state==RUN
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset: one clock, synchronous, active-high. reset=1 at an edge forces state=IDLE, cnt=0, HI=0, LO=0, hi_tmp=lo_tmp=0, busy=0. Reset overrides everything, including mid-operation; the aborted result is discarded.
- State machine: IDLE, RUN. busy = (state==RUN), registered, not derived from md_en.
- IDLE, md_en=1, md_op in 0..3, at edge t0:
  - compute the result combinationally from A/B and latch it into hi_tmp/lo_tmp
  - load cnt with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3); state to RUN
  - busy is high after edges t0..t0+N-1 (N cycles); HI/LO update at edge t0+N; busy low after t0+N.
- RUN, each edge: cnt decrements. When cnt==1 at an edge: HI<=hi_tmp, LO<=lo_tmp, state to IDLE, cnt to 0.
- IDLE, md_en=1, md_op=4 (MTHI): HI<=A at that edge. md_op=5 (MTLO): LO<=A. Single cycle; busy stays 0.
- md_op 6/7, or md_en=0: no state change.
- md_en=1 during RUN: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this never occurs; the bench checks that it is ignored.
- Arithmetic:
  - MULT: signed 32x32 to 64; HI=product[63:32], LO=product[31:0].
  - MULTU: unsigned, same split.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend (A).
  - DIVU: unsigned quotient/remainder.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divide by zero (B==0, DIV or DIVU): the unit still runs DIV_CYCLES with busy high; at completion HI and LO keep their pre-operation values (hi_tmp/lo_tmp loaded from the current HI/LO).
- HI/LO outputs reflect registered values only. No bypass of hi_tmp/lo_tmp before completion.
- Back-to-back: a new operation may be accepted at the edge immediately after busy falls (state IDLE). It cannot be accepted at the completion edge itself.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, release -> HI=0, LO=0, busy=0. Assert reset at cycle 3 of a DIV -> busy=0 next cycle, HI/LO=0, no later update.
- MULT A=0xFFFFFFFE (-2), B=3, md_en pulse at t0 -> busy=1 for 5 cycles; at edge t0+5 HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: MTHI A=0x1234, MTLO A=0x5678, then DIVU B=0 -> busy high for 10 cycles, then HI=0x1234, LO=0x5678.
- Ignore while busy: start MULT 2*3; during RUN drive md_en=1 with MTLO A=0xDEAD and with DIV -> no effect; final HI=0, LO=6; busy length stays 5.
- Back-to-back: MULT 4*5 then DIVU 100/7, issued the cycle busy falls -> LO=20 at t0+5; DIVU accepted at t0+6; LO=14, HI=2 at t0+16.

Source files
------------

// File: rtl/mdu_unit.sv
// -----------------------------------------------------------------------------
// mdu_unit -- execute-stage multiply/divide unit with HI/LO ownership.
//
// The result of MULT/MULTU/DIV/DIVU is computed combinationally at acceptance
// and parked in hi_tmp/lo_tmp. A down-counter then models the multi-cycle
// latency before the architectural HI/LO registers are written. MTHI/MTLO
// write HI/LO directly in a single cycle while idle.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous, active-high reset
//   md_en  in   1   qualifies md_op (E-stage MDU write-type instruction)
//   md_op  in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 none
//   A      in  32   rs operand (forwarded)
//   B      in  32   rt operand (forwarded)
//   busy   out  1   high exactly while an operation is in flight
//   HI     out 32   architectural HI register
//   LO     out 32   architectural LO register
// -----------------------------------------------------------------------------
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_en,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   hi_q,    hi_d;
    logic [31:0]   lo_q,    lo_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d;
    logic [31:0]   lo_tmp_q, lo_tmp_d;

    // ---------------------------------------------------------------- datapath
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
    logic [31:0] sq_mag, sr_mag, q_s, r_s, q_u, r_u;
    logic        b_zero;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    assign b_zero = (B == 32'd0);

    // Signed divide is done on magnitudes so that 0x80000000 / -1 falls out
    // naturally (magnitude 0x80000000, same signs -> quotient 0x80000000).
    assign a_mag    = A[31] ? (~A + 32'd1) : A;
    assign b_mag    = B[31] ? (~B + 32'd1) : B;
    // Zero divisor is replaced by 1 only to keep the divider defined; the
    // result is discarded in that case.
    assign b_mag_nz = b_zero ? 32'd1 : b_mag;
    assign b_nz     = b_zero ? 32'd1 : B;

    assign sq_mag = a_mag / b_mag_nz;
    assign sr_mag = a_mag % b_mag_nz;
    assign q_s    = (A[31] ^ B[31]) ? (~sq_mag + 32'd1) : sq_mag;
    assign r_s    = A[31] ? (~sr_mag + 32'd1) : sr_mag;
    assign q_u    = A / b_nz;
    assign r_u    = A % b_nz;

    // ---------------------------------------------------------------- control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;

        if (state_q == IDLE) begin
            if (md_en) begin
                case (md_op)
                    OP_MULT: begin
                        {hi_tmp_d, lo_tmp_d} = prod_s;
                        cnt_d   = CW'(MULT_CYCLES);
                        state_d = RUN;
                    end
                    OP_MULTU: begin
                        {hi_tmp_d, lo_tmp_d} = prod_u;
                        cnt_d   = CW'(MULT_CYCLES);
                        state_d = RUN;
                    end
                    OP_DIV: begin
                        hi_tmp_d = b_zero ? hi_q : r_s;
                        lo_tmp_d = b_zero ? lo_q : q_s;
                        cnt_d    = CW'(DIV_CYCLES);
                        state_d  = RUN;
                    end
                    OP_DIVU: begin
                        hi_tmp_d = b_zero ? hi_q : r_u;
                        lo_tmp_d = b_zero ? lo_q : q_u;
                        cnt_d    = CW'(DIV_CYCLES);
                        state_d  = RUN;
                    end
                    OP_MTHI: hi_d = A;
                    OP_MTLO: lo_d = A;
                    default: ;
                endcase
            end
        end else begin
            // Any md_en during RUN is dropped on the floor.
            if (cnt_q == CW'(1)) begin
                hi_d    = hi_tmp_q;
                lo_d    = lo_tmp_q;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    assign busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_en;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int n_chk  = 0;
    int n_fail = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .md_en(md_en),
        .md_op(md_op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, count busy cycles (bounded), confirm HI/LO hold their
    // pre-op values while busy, then check the final HI/LO.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int n,
                         input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int   len;
        logic leak;
        md_en = 1'b1; md_op = op; A = a; B = b;
        tick();
        md_en = 1'b0;
        len  = 0;
        leak = 1'b0;
        while (busy === 1'b1 && len < 50) begin
            len++;
            if (HI !== pre_hi || LO !== pre_lo) leak = 1'b1;
            tick();
        end
        check({tag, "_busy_len"}, 32'(len), 32'(n));
        check({tag, "_no_bypass"}, {31'd0, leak}, 32'd0);
        check({tag, "_HI"}, HI, exp_hi);
        check({tag, "_LO"}, LO, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        reset = 1'b1; md_en = 1'b0; md_op = 3'd0; A = '0; B = '0;
        #1;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_HI", HI, 32'd0);
        check("rst_LO", LO, 32'd0);

        // Reset in the middle of a divide: nothing may survive.
        md_en = 1'b1; md_op = 3'd4; A = 32'h0000AAAA;
        tick();
        md_op = 3'd2; A = 32'd9; B = 32'd2;
        tick();
        md_en = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_HI", HI, 32'd0);
        check("rst_mid_LO", LO, 32'd0);
        repeat (12) tick();
        check("rst_mid_late_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_late_HI", HI, 32'd0);
        check("rst_mid_late_LO", LO, 32'd0);

        // Multiply / divide arithmetic.
        do_op("mult",  3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'h0, 32'h0,
              32'hFFFFFFFF, 32'hFFFFFFFA);
        do_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA,
              32'h00000002, 32'hFFFFFFFA);
        do_op("div",   3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'h00000002, 32'hFFFFFFFA,
              32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu",  3'd3, 32'd7, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD,
              32'd1, 32'd3);
        do_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd1, 32'd3,
              32'd0, 32'h80000000);

        // MTHI / MTLO are single cycle.
        md_en = 1'b1; md_op = 3'd4; A = 32'h1234;
        tick();
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_HI", HI, 32'h1234);
        md_op = 3'd5; A = 32'h5678;
        tick();
        md_en = 1'b0;
        check("mtlo_LO", LO, 32'h5678);
        check("mtlo_HI_kept", HI, 32'h1234);

        // Reserved op leaves everything alone.
        md_en = 1'b1; md_op = 3'd6; A = 32'hFFFF;
        tick();
        md_en = 1'b0;
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        check("rsvd_HI", HI, 32'h1234);

        do_op("divu_by0", 3'd3, 32'd99, 32'd0, 10, 32'h1234, 32'h5678,
              32'h1234, 32'h5678);
        do_op("div_by0", 3'd2, 32'hFFFFFF00, 32'd0, 10, 32'h1234, 32'h5678,
              32'h1234, 32'h5678);

        // md_en during RUN (including the completion edge) is ignored.
        md_en = 1'b1; md_op = 3'd0; A = 32'd2; B = 32'd3;
        tick();                                   // t0
        len = busy ? 1 : 0;
        md_op = 3'd5; A = 32'hDEAD;
        tick();                                   // t0+1
        len += busy ? 1 : 0;
        md_op = 3'd2; A = 32'd100; B = 32'd7;
        tick();                                   // t0+2
        len += busy ? 1 : 0;
        md_en = 1'b0;
        tick();                                   // t0+3
        len += busy ? 1 : 0;
        md_en = 1'b1; md_op = 3'd5; A = 32'hDEAD;
        tick();                                   // t0+4
        len += busy ? 1 : 0;
        check("ign_LO_held", LO, 32'h5678);
        tick();                                   // t0+5 completion
        md_en = 1'b0;
        check("ign_busy_len", 32'(len), 32'd5);
        check("ign_busy_done", {31'd0, busy}, 32'd0);
        check("ign_HI", HI, 32'd0);
        check("ign_LO", LO, 32'd6);
        tick();
        check("ign_no_late_busy", {31'd0, busy}, 32'd0);
        check("ign_LO_late", LO, 32'd6);

        // Back-to-back: second op issued right after busy falls.
        do_op("b2b_mult", 3'd0, 32'd4, 32'd5, 5, 32'd0, 32'd6, 32'd0, 32'd20);
        do_op("b2b_divu", 3'd3, 32'd100, 32'd7, 10, 32'd0, 32'd20, 32'd2, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
